// File: rtl/io_input_scheduler_if.sv
// rtl/io_input_scheduler_if.sv - processor-side input word request and interrupt handshake
interface io_input_scheduler_if #(
  parameter int WIDTH = 15
);
  logic             in_req;
  logic             in_ack;
  logic [WIDTH-1:0] in_data;
  logic             irq;
  logic             irq_ack;

  modport master (output in_req, output irq_ack, input in_ack, input in_data, input irq);
  modport slave  (input in_req, input irq_ack, output in_ack, output in_data, output irq);
endinterface

// File: rtl/io_input_scheduler.sv
// rtl/io_input_scheduler.sv - debounced enter/interrupt buttons feeding a switch-word capture FSM
module io_input_scheduler #(
  parameter int          WIDTH    = 15,
  parameter logic [15:0] DEBOUNCE = 16'd50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enter,
  input  logic                interruption,
  input  logic [WIDTH-1:0]    switches,
  output logic                LED,
  io_input_scheduler_if.slave bus
);

  localparam logic [15:0] DEB_LAST = DEBOUNCE - 16'd1;

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, ACK} state_t;

  state_t           state, state_next;
  logic [1:0]       btn_s1, btn_s2, btn_lvl, btn_flip;  // bit 0 = enter, bit 1 = interruption
  logic [15:0]      btn_cnt [2];
  logic [WIDTH-1:0] sw_s1, sw_s2, data_q;
  logic             irq_q, capture;
  logic             enter_press, enter_release, intr_press;

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_s1 <= 2'b11;
      btn_s2 <= 2'b11;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {interruption, enter};
      btn_s2 <= btn_s1;
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
    end
  end

  // A flip fires on the edge where the mismatch count would reach DEBOUNCE.
  always_comb begin
    btn_flip = '0;
    for (int b = 0; b < 2; b++)
      btn_flip[b] = (btn_s2[b] != btn_lvl[b]) && (btn_cnt[b] == DEB_LAST);
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 2; b++) begin
      if (!reset) begin
        btn_lvl[b] <= 1'b1;
        btn_cnt[b] <= '0;
      end else if (btn_flip[b]) begin
        btn_lvl[b] <= ~btn_lvl[b];
        btn_cnt[b] <= '0;
      end else if (btn_s2[b] != btn_lvl[b]) begin
        btn_cnt[b] <= btn_cnt[b] + 16'd1;
      end else begin
        btn_cnt[b] <= '0;
      end
    end
  end

  assign enter_press   = btn_flip[0] &  btn_lvl[0];
  assign enter_release = btn_flip[0] & ~btn_lvl[0];
  assign intr_press    = btn_flip[1] &  btn_lvl[1];

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    LED        = 1'b0;
    bus.in_ack = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        LED = 1'b1;
        if (!bus.in_req) begin
          state_next = IDLE;
        end else if (enter_press) begin
          capture    = 1'b1;
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!bus.in_req)        state_next = IDLE;
        else if (enter_release) state_next = ACK;
      end
      ACK: begin
        bus.in_ack = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A press in the same cycle as irq_ack wins so that interrupt is not lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (capture) data_q <= sw_s2;
      if (intr_press)       irq_q <= 1'b1;
      else if (bus.irq_ack) irq_q <= 1'b0;
    end
  end

  assign bus.in_data = data_q;
  assign bus.irq     = irq_q;

endmodule
